// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: groups the instruction port, data port, shared bus and
// stall outputs of mem_arbiter into one bundle.
// master = arbiter view (it masters the shared bus and answers both requesters);
// slave  = environment view (requesters, bus slave and pipeline).
interface mem_arbiter_if;
   // instruction fetch port
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   // data load/store port
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   // shared bus
   logic        bus_req;
   logic        bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;
   // pipeline stalls
   logic        i_busy;
   logic        d_busy;

   modport master (
      input  inst_req, inst_addr,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
      input  bus_addr_ok, bus_data_ok, bus_rdata,
      output i_busy, d_busy
   );

   modport slave (
      output inst_req, inst_addr,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
      output bus_addr_ok, bus_data_ok, bus_rdata,
      input  i_busy, d_busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one address/data-handshake bus between the instruction
// fetch port and the data load/store port, one transaction at a time.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie-breaking;
// without it the data port always wins simultaneous requests.
module mem_arbiter (
   input logic           clk,
   input logic           rst,
   mem_arbiter_if.master arb
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_e;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_e;

   state_e      state_q, state_d;
   owner_e      owner_q, owner_d;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;

   logic        any_req;
   logic        grant_data;   // winner when a grant is made in IDLE
   logic        completing;   // DATA phase finishing this cycle

   assign any_req = arb.inst_req | arb.data_req;

`ifdef MEM_ARB_RR_EN
   owner_e last_q, last_d;

   // tie goes to the requester that was not granted last
   always_comb begin
      if (arb.inst_req && arb.data_req) begin
         grant_data = (last_q == OWN_INST);
      end else begin
         grant_data = arb.data_req;
      end
   end

   // remember every grant so the next tie flips
   always_comb begin
      last_d = last_q;
      if (state_q == IDLE && any_req) begin
         last_d = grant_data ? OWN_DATA : OWN_INST;
      end
   end

   // last-grant register; reset to INST so data wins the first tie
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= OWN_INST;
      end else begin
         last_q <= last_d;
      end
   end
`else
   // fixed priority: data wins whenever it requests
   always_comb begin
      grant_data = arb.data_req;
   end
`endif

   // state, owner and latched transaction fields
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= OWN_INST;
         wr_q    <= '0;
         size_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // next state, field latching and combinational handshake forwarding
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      wr_d     = wr_q;
      size_d   = size_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;

      arb.bus_req      = 1'b0;
      arb.bus_wr       = 1'b0;
      arb.bus_size     = '0;
      arb.bus_addr     = '0;
      arb.bus_wdata    = '0;
      arb.inst_addr_ok = 1'b0;
      arb.inst_data_ok = 1'b0;
      arb.inst_rdata   = '0;
      arb.data_addr_ok = 1'b0;
      arb.data_data_ok = 1'b0;
      arb.data_rdata   = '0;
      completing       = 1'b0;

      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = ADDR;
               if (grant_data) begin
                  owner_d = OWN_DATA;
                  wr_d    = arb.data_wr;
                  size_d  = arb.data_size;
                  addr_d  = arb.data_addr;
                  wdata_d = arb.data_wdata;
               end else begin
                  // fetches are always word reads
                  owner_d = OWN_INST;
                  wr_d    = 1'b0;
                  size_d  = 2'd2;
                  addr_d  = arb.inst_addr;
                  wdata_d = '0;
               end
            end
         end

         ADDR: begin
            arb.bus_req   = 1'b1;
            arb.bus_wr    = wr_q;
            arb.bus_size  = size_q;
            arb.bus_addr  = addr_q;
            arb.bus_wdata = wdata_q;
            if (owner_q == OWN_DATA) begin
               arb.data_addr_ok = arb.bus_addr_ok;
            end else begin
               arb.inst_addr_ok = arb.bus_addr_ok;
            end
            if (arb.bus_addr_ok) begin
               state_d = DATA;
            end
         end

         DATA: begin
            arb.inst_rdata = arb.bus_rdata;
            arb.data_rdata = arb.bus_rdata;
            completing     = arb.bus_data_ok;
            if (owner_q == OWN_DATA) begin
               arb.data_data_ok = arb.bus_data_ok;
            end else begin
               arb.inst_data_ok = arb.bus_data_ok;
            end
            if (arb.bus_data_ok) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // stall while a request waits or an owned transaction is still open;
      // the completion cycle itself releases the stall
      arb.i_busy = (arb.inst_req && !(completing && owner_q == OWN_INST)) ||
                   (owner_q == OWN_INST && state_q != IDLE && !completing);
      arb.d_busy = (arb.data_req && !(completing && owner_q == OWN_DATA)) ||
                   (owner_q == OWN_DATA && state_q != IDLE && !completing);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by a randomized run checked
// against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   int unsigned checks   = 0;
   int unsigned failures = 0;

   always #5 clk = ~clk;

   mem_arbiter_if bif ();

   mem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .arb (bif)
   );

   // expected winners of three back-to-back ties straight after reset
`ifdef MEM_ARB_RR_EN
   bit tie_data [3] = '{1'b1, 1'b0, 1'b1};
`else
   bit tie_data [3] = '{1'b1, 1'b1, 1'b1};
`endif

   // reference model: one outstanding transaction record
   bit          m_busy, m_acc, m_own, m_last, cmpl, win;
   bit          inst_drop, data_drop;
   logic        e_wr;
   logic [1:0]  e_size;
   logic [31:0] e_addr, e_wdata, tie_addr;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %b want %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   // on a tie, pick the side not granted last (round-robin) or data (fixed)
   function automatic bit tie_pick(input bit last_was_data);
`ifdef MEM_ARB_RR_EN
      return !last_was_data;
`else
      return 1'b1;
`endif
   endfunction

   task automatic quiet();
      bif.inst_req    = 1'b0;
      bif.inst_addr   = '0;
      bif.data_req    = 1'b0;
      bif.data_wr     = 1'b0;
      bif.data_size   = '0;
      bif.data_addr   = '0;
      bif.data_wdata  = '0;
      bif.bus_addr_ok = 1'b0;
      bif.bus_data_ok = 1'b0;
      bif.bus_rdata   = '0;
   endtask

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      quiet();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      sample();
      chk1 ("rst bus_req",      bif.bus_req,      1'b0);
      chk1 ("rst inst_addr_ok", bif.inst_addr_ok, 1'b0);
      chk1 ("rst inst_data_ok", bif.inst_data_ok, 1'b0);
      chk1 ("rst data_addr_ok", bif.data_addr_ok, 1'b0);
      chk1 ("rst data_data_ok", bif.data_data_ok, 1'b0);
      chk1 ("rst i_busy",       bif.i_busy,       1'b0);
      chk1 ("rst d_busy",       bif.d_busy,       1'b0);
      chk32("rst bus_addr",     bif.bus_addr,     32'h0);

      // single fetch with two address wait cycles
      drive_edge(); bif.inst_req = 1'b1; bif.inst_addr = 32'hBFC00000; sample();
      chk1 ("fetch idle bus_req", bif.bus_req, 1'b0);
      chk1 ("fetch idle i_busy",  bif.i_busy,  1'b1);
      drive_edge(); sample();
      chk1 ("fetch w1 bus_req",   bif.bus_req, 1'b1);
      chk32("fetch bus_addr",     bif.bus_addr, 32'hBFC00000);
      chk1 ("fetch bus_wr",       bif.bus_wr, 1'b0);
      chk32("fetch bus_size",     32'(bif.bus_size), 32'd2);
      chk1 ("fetch w1 addr_ok",   bif.inst_addr_ok, 1'b0);
      drive_edge(); sample();
      chk1 ("fetch w2 bus_req",   bif.bus_req, 1'b1);
      chk1 ("fetch w2 addr_ok",   bif.inst_addr_ok, 1'b0);
      drive_edge(); bif.bus_addr_ok = 1'b1; sample();
      chk1 ("fetch inst_addr_ok", bif.inst_addr_ok, 1'b1);
      chk1 ("fetch data_addr_ok", bif.data_addr_ok, 1'b0);
      chk1 ("fetch ack i_busy",   bif.i_busy, 1'b1);
      drive_edge(); bif.bus_addr_ok = 1'b0; bif.inst_req = 1'b0;
      bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'h3C080001; sample();
      chk1 ("fetch addr_ok pulse", bif.inst_addr_ok, 1'b0);
      chk1 ("fetch inst_data_ok",  bif.inst_data_ok, 1'b1);
      chk1 ("fetch data_data_ok",  bif.data_data_ok, 1'b0);
      chk32("fetch inst_rdata",    bif.inst_rdata, 32'h3C080001);
      chk1 ("fetch done i_busy",   bif.i_busy, 1'b0);
      drive_edge(); bif.bus_data_ok = 1'b0; sample();
      chk1 ("fetch data_ok pulse", bif.inst_data_ok, 1'b0);
      chk1 ("fetch after bus_req", bif.bus_req, 1'b0);

      // simultaneous store and fetch: store goes first
      drive_edge();
      bif.inst_req = 1'b1; bif.inst_addr = 32'h00001000;
      bif.data_req = 1'b1; bif.data_wr = 1'b1; bif.data_size = 2'd0;
      bif.data_addr = 32'h80000004; bif.data_wdata = 32'h000000AB;
      sample();
      chk1 ("tie idle d_busy", bif.d_busy, 1'b1);
      chk1 ("tie idle i_busy", bif.i_busy, 1'b1);
      drive_edge(); bif.bus_addr_ok = 1'b1; sample();
      chk1 ("tie bus_req",      bif.bus_req, 1'b1);
      chk1 ("tie bus_wr",       bif.bus_wr, 1'b1);
      chk32("tie bus_size",     32'(bif.bus_size), 32'd0);
      chk32("tie bus_addr",     bif.bus_addr, 32'h80000004);
      chk32("tie bus_wdata",    bif.bus_wdata, 32'h000000AB);
      chk1 ("tie data_addr_ok", bif.data_addr_ok, 1'b1);
      chk1 ("tie inst_addr_ok", bif.inst_addr_ok, 1'b0);
      drive_edge(); bif.bus_addr_ok = 1'b0; bif.data_req = 1'b0;
      bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'h0; sample();
      chk1 ("tie data_data_ok", bif.data_data_ok, 1'b1);
      chk1 ("tie inst_data_ok", bif.inst_data_ok, 1'b0);
      chk1 ("tie K d_busy",     bif.d_busy, 1'b0);
      chk1 ("tie K i_busy",     bif.i_busy, 1'b1);
      drive_edge(); bif.bus_data_ok = 1'b0; sample();
      chk1 ("tie K+1 bus_req",  bif.bus_req, 1'b0);
      drive_edge(); bif.bus_addr_ok = 1'b1; sample();
      chk1 ("tie K+2 bus_req",  bif.bus_req, 1'b1);
      chk32("tie K+2 bus_addr", bif.bus_addr, 32'h00001000);
      chk1 ("tie K+2 bus_wr",   bif.bus_wr, 1'b0);
      chk1 ("tie K+2 addr_ok",  bif.inst_addr_ok, 1'b1);
      drive_edge(); bif.bus_addr_ok = 1'b0; bif.inst_req = 1'b0; bif.bus_data_ok = 1'b1; sample();
      chk1 ("tie inst done",    bif.inst_data_ok, 1'b1);
      drive_edge(); bif.bus_data_ok = 1'b0;

      // three consecutive ties straight out of reset
      rst = 1'b1; sample();
      drive_edge(); rst = 1'b0;
      bif.inst_req = 1'b1; bif.inst_addr = 32'h00002000;
      bif.data_req = 1'b1; bif.data_wr = 1'b0; bif.data_size = 2'd2; bif.data_addr = 32'h00003000;
      sample();
      for (int t = 0; t < 3; t++) begin
         tie_addr = tie_data[t] ? 32'h00003000 : 32'h00002000;
         drive_edge(); bif.bus_addr_ok = 1'b1; sample();
         chk32("rr grant addr",    bif.bus_addr, tie_addr);
         chk1 ("rr data_addr_ok",  bif.data_addr_ok, tie_data[t]);
         chk1 ("rr inst_addr_ok",  bif.inst_addr_ok, !tie_data[t]);
         drive_edge(); bif.bus_addr_ok = 1'b0; bif.bus_data_ok = 1'b1; sample();
         chk1 ("rr data_data_ok",  bif.data_data_ok, tie_data[t]);
         chk1 ("rr inst_data_ok",  bif.inst_data_ok, !tie_data[t]);
         drive_edge(); bif.bus_data_ok = 1'b0; sample();
      end
      drive_edge(); bif.inst_req = 1'b0; bif.data_req = 1'b0; bif.bus_addr_ok = 1'b1;
      drive_edge(); bif.bus_addr_ok = 1'b0; bif.bus_data_ok = 1'b1;
      drive_edge(); bif.bus_data_ok = 1'b0; sample();

      // stray handshakes in the wrong phase are ignored
      drive_edge(); bif.inst_req = 1'b1; bif.inst_addr = 32'h00004000; sample();
      drive_edge(); bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'hDEADBEEF; sample();
      chk1 ("spur ADDR inst_data_ok", bif.inst_data_ok, 1'b0);
      chk1 ("spur ADDR data_data_ok", bif.data_data_ok, 1'b0);
      chk1 ("spur ADDR bus_req",      bif.bus_req, 1'b1);
      drive_edge(); bif.bus_data_ok = 1'b0; sample();
      chk1 ("spur ADDR held",         bif.bus_req, 1'b1);
      drive_edge(); bif.bus_addr_ok = 1'b1; sample();
      chk1 ("spur ack",               bif.inst_addr_ok, 1'b1);
      drive_edge(); bif.inst_req = 1'b0; sample();
      chk1 ("spur DATA inst_addr_ok", bif.inst_addr_ok, 1'b0);
      chk1 ("spur DATA data_addr_ok", bif.data_addr_ok, 1'b0);
      chk1 ("spur DATA inst_data_ok", bif.inst_data_ok, 1'b0);
      chk1 ("spur DATA i_busy",       bif.i_busy, 1'b1);
      chk1 ("spur DATA bus_req",      bif.bus_req, 1'b0);
      drive_edge(); bif.bus_addr_ok = 1'b0; bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'h12345678; sample();
      chk1 ("spur done data_ok",      bif.inst_data_ok, 1'b1);
      chk32("spur done rdata",        bif.inst_rdata, 32'h12345678);
      drive_edge(); bif.bus_data_ok = 1'b0; sample();

      // reset during a data-owned DATA phase with a fetch pending
      drive_edge(); bif.data_req = 1'b1; bif.data_wr = 1'b0; bif.data_size = 2'd2;
      bif.data_addr = 32'h00005000; sample();
      drive_edge(); bif.bus_addr_ok = 1'b1; bif.inst_req = 1'b1; bif.inst_addr = 32'h00006000; sample();
      chk1 ("mid data_addr_ok", bif.data_addr_ok, 1'b1);
      drive_edge(); bif.bus_addr_ok = 1'b0; bif.data_req = 1'b0; sample();
      chk1 ("mid DATA d_busy",  bif.d_busy, 1'b1);
      drive_edge(); rst = 1'b1; sample();
      drive_edge(); rst = 1'b0; sample();
      chk1 ("mid rst bus_req",  bif.bus_req, 1'b0);
      chk1 ("mid rst d_busy",   bif.d_busy, 1'b0);
      chk1 ("mid rst data_ok",  bif.data_data_ok, 1'b0);
      chk1 ("mid rst i_busy",   bif.i_busy, 1'b1);
      drive_edge(); sample();
      chk1 ("mid regrant req",  bif.bus_req, 1'b1);
      chk32("mid regrant addr", bif.bus_addr, 32'h00006000);
      drive_edge(); bif.bus_addr_ok = 1'b1;
      drive_edge(); bif.bus_addr_ok = 1'b0; bif.inst_req = 1'b0; bif.bus_data_ok = 1'b1;
      drive_edge(); bif.bus_data_ok = 1'b0;

      // randomized traffic against the transaction model
      rst = 1'b1; quiet(); sample();
      m_busy = 1'b0; m_acc = 1'b0; m_own = 1'b0; m_last = 1'b0;
      inst_drop = 1'b0; data_drop = 1'b0;
      e_wr = 1'b0; e_size = '0; e_addr = '0; e_wdata = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         drive_edge();
         rst = 1'b0;
         if (inst_drop) begin bif.inst_req = 1'b0; inst_drop = 1'b0; end
         if (data_drop) begin bif.data_req = 1'b0; data_drop = 1'b0; end
         if (!bif.inst_req && $urandom_range(0, 3) == 0) begin
            bif.inst_req  = 1'b1;
            bif.inst_addr = $urandom & 32'hFFFFFFFC;
         end
         if (!bif.data_req && $urandom_range(0, 3) == 0) begin
            bif.data_req   = 1'b1;
            bif.data_wr    = 1'($urandom_range(0, 1));
            bif.data_size  = 2'($urandom_range(0, 2));
            bif.data_addr  = $urandom;
            bif.data_wdata = $urandom;
         end
         bif.bus_addr_ok = (m_busy && !m_acc) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         bif.bus_data_ok = (m_busy &&  m_acc) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         bif.bus_rdata   = $urandom;
         sample();

         cmpl = m_busy && m_acc && bif.bus_data_ok;
         chk1("rnd bus_req", bif.bus_req, m_busy && !m_acc);
         if (m_busy && !m_acc) begin
            chk32("rnd bus_addr", bif.bus_addr, e_addr);
            chk1 ("rnd bus_wr",   bif.bus_wr, e_wr);
            chk32("rnd bus_size", 32'(bif.bus_size), 32'(e_size));
            if (e_wr) chk32("rnd bus_wdata", bif.bus_wdata, e_wdata);
         end
         chk1("rnd inst_addr_ok", bif.inst_addr_ok, m_busy && !m_acc && !m_own && bif.bus_addr_ok);
         chk1("rnd data_addr_ok", bif.data_addr_ok, m_busy && !m_acc &&  m_own && bif.bus_addr_ok);
         chk1("rnd inst_data_ok", bif.inst_data_ok, cmpl && !m_own);
         chk1("rnd data_data_ok", bif.data_data_ok, cmpl &&  m_own);
         if (m_busy && m_acc) begin
            chk32("rnd inst_rdata", bif.inst_rdata, bif.bus_rdata);
            chk32("rnd data_rdata", bif.data_rdata, bif.bus_rdata);
         end
         chk1("rnd i_busy", bif.i_busy,
              (bif.inst_req && !(cmpl && !m_own)) || (m_busy && !m_own && !cmpl));
         chk1("rnd d_busy", bif.d_busy,
              (bif.data_req && !(cmpl && m_own)) || (m_busy && m_own && !cmpl));

         if (m_busy) begin
            if (!m_acc) begin
               if (bif.bus_addr_ok) begin
                  m_acc = 1'b1;
                  if (m_own) data_drop = 1'b1;
                  else       inst_drop = 1'b1;
               end
            end else if (bif.bus_data_ok) begin
               m_busy = 1'b0;
            end
         end else if (bif.inst_req || bif.data_req) begin
            win    = (bif.inst_req && bif.data_req) ? tie_pick(m_last) : bif.data_req;
            m_busy = 1'b1;
            m_acc  = 1'b0;
            m_own  = win;
            m_last = win;
            if (win) begin
               e_wr = bif.data_wr; e_size = bif.data_size; e_addr = bif.data_addr; e_wdata = bif.data_wdata;
            end else begin
               e_wr = 1'b0; e_size = 2'd2; e_addr = bif.inst_addr; e_wdata = '0;
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
